// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: bus request and
// response structs plus the arbiter FSM state encoding.
package mem_arbiter_pkg;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
   } ibus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } ibus_resp_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      logic [2:0]  size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [63:0] addr;
      logic [2:0]  size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } mbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } mbus_resp_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } arb_state_e;

   // Instruction fetches are always 4-byte reads.
   localparam logic [2:0] IFETCH_SIZE = 3'b010;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the three buses around the arbiter. Handshake: a requester holds
// valid (and its fields) until the response with data_ok=1; addr_ok/data_ok
// are one-cycle strobes from the memory side, forwarded only to the granted
// requester.
interface mem_arbiter_if;
   import mem_arbiter_pkg::*;

   ibus_req_t  ireq;
   ibus_resp_t iresp;
   dbus_req_t  dreq;
   dbus_resp_t dresp;
   mbus_req_t  mreq;
   mbus_resp_t mresp;

   // Arbiter side: consumes both requesters, drives the shared memory bus.
   modport master (
      input  ireq, dreq, mresp,
      output iresp, dresp, mreq
   );

   // Environment side: requesters and memory model.
   modport slave (
      output ireq, dreq, mresp,
      input  iresp, dresp, mreq
   );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: data bus wins by default, instruction bus is
// forced through after STARVE_MAX consecutive data grants taken while it
// waited. One grant at a time, always separated by an IDLE cycle.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  ibus_req_t                        ireq,
   output ibus_resp_t                       iresp,
   input  dbus_req_t                        dreq,
   output dbus_resp_t                       dresp,
   output mbus_req_t                        mreq,
   input  mbus_resp_t                       mresp,
   // debug visibility of internal state
   output arb_state_e                       state,
   output logic [$clog2(STARVE_MAX+1)-1:0]  starve_cnt
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   // FSM and starvation counter; a grant is released only by data_ok, even
   // if the requester withdraws valid early.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         starve_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (ireq.valid && (!dreq.valid || starve_cnt == CNT_MAX)) begin
                  state      <= GRANT_I;
                  starve_cnt <= '0;
               end else if (dreq.valid) begin
                  state <= GRANT_D;
                  if (ireq.valid && starve_cnt != CNT_MAX)
                     starve_cnt <= starve_cnt + 1'b1;
               end
            end
            GRANT_I, GRANT_D: begin
               if (mresp.data_ok)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Bus steering from the registered state; responses pass straight through
   // to the granted side, the other side sees zeros.
   always_comb begin
      mreq  = '0;
      iresp = '0;
      dresp = '0;
      case (state)
         GRANT_D: begin
            mreq.valid    = 1'b1;
            mreq.is_write = |dreq.strobe;
            mreq.addr     = dreq.addr;
            mreq.size     = dreq.size;
            mreq.strobe   = dreq.strobe;
            mreq.data     = dreq.data;
            dresp.addr_ok = mresp.addr_ok;
            dresp.data_ok = mresp.data_ok;
            dresp.data    = mresp.data;
         end
         GRANT_I: begin
            mreq.valid    = 1'b1;
            mreq.addr     = ireq.addr;
            mreq.size     = IFETCH_SIZE;
            iresp.addr_ok = mresp.addr_ok;
            iresp.data_ok = mresp.data_ok;
            iresp.data    = ireq.addr[2] ? mresp.data[63:32] : mresp.data[31:0];
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch lane select, priority,
// store, early-drop, starvation and asynchronous reset mid-grant.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic       clk;
   logic       reset;
   arb_state_e state;
   logic [2:0] starve_cnt;
   int         total;
   int         bad;
   logic [63:0] exp_q[$];

   mem_arbiter_if bus();

   mem_arbiter #(.STARVE_MAX(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .ireq       (bus.ireq),
      .iresp      (bus.iresp),
      .dreq       (bus.dreq),
      .dresp      (bus.dresp),
      .mreq       (bus.mreq),
      .mresp      (bus.mresp),
      .state      (state),
      .starve_cnt (starve_cnt)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_inputs();
      bus.ireq  = '0;
      bus.dreq  = '0;
      bus.mresp = '0;
   endtask

   // one-cycle memory answer on the current grant, then back to IDLE
   task automatic answer(input logic [63:0] data);
      bus.mresp.addr_ok = 1'b1;
      bus.mresp.data_ok = 1'b1;
      bus.mresp.data    = data;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      clear_inputs();
      reset = 1'b1;
      // memory noise during reset must not leak out
      bus.mresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'hDEAD_BEEF_0000_0001};
      bus.dreq.valid = 1'b1;
      repeat (2) tick();
      check("rst_state", 64'(state), 64'(IDLE));
      check("rst_mvalid", 64'(bus.mreq.valid), 64'd0);
      check("rst_iresp", 64'(bus.iresp), 64'd0);
      check("rst_dresp", 64'(bus.dresp), 64'd0);
      check("rst_starve", 64'(starve_cnt), 64'd0);
      clear_inputs();
      reset = 1'b0;

      // single instruction fetch, upper lane
      bus.ireq = '{valid: 1'b1, addr: 64'h8000_0004};
      settle();
      check("if_idle_mvalid", 64'(bus.mreq.valid), 64'd0);
      tick();
      check("if_state", 64'(state), 64'(GRANT_I));
      check("if_maddr", bus.mreq.addr, 64'h8000_0004);
      check("if_msize", 64'(bus.mreq.size), 64'd2);
      check("if_mstrobe", 64'(bus.mreq.strobe), 64'd0);
      check("if_mwrite", 64'(bus.mreq.is_write), 64'd0);
      tick();
      tick();
      check("if_hold", 64'(state), 64'(GRANT_I));
      answer(64'hAABBCCDD_11223344);
      settle();
      check("if_data_hi", 64'(bus.iresp.data), 64'hAABBCCDD);
      check("if_data_ok", 64'(bus.iresp.data_ok), 64'd1);
      check("if_dresp_quiet", 64'(bus.dresp), 64'd0);
      tick();
      clear_inputs();
      check("if_back_idle", 64'(state), 64'(IDLE));

      // lower lane
      bus.ireq = '{valid: 1'b1, addr: 64'h8000_0008};
      tick();
      answer(64'hAABBCCDD_11223344);
      settle();
      check("if_data_lo", 64'(bus.iresp.data), 64'h11223344);
      tick();
      clear_inputs();

      // simultaneous requests: data first, instruction after data_ok
      bus.ireq = '{valid: 1'b1, addr: 64'h8000_0010};
      bus.dreq = '{valid: 1'b1, addr: 64'h0000_2000, size: 3'b011, strobe: 8'h00, data: 64'h0};
      tick();
      check("sim_first_d", 64'(state), 64'(GRANT_D));
      check("sim_maddr", bus.mreq.addr, 64'h0000_2000);
      check("sim_load_rd", 64'(bus.mreq.is_write), 64'd0);
      answer(64'h0102_0304_0506_0708);
      settle();
      check("sim_ddata", bus.dresp.data, 64'h0102_0304_0506_0708);
      check("sim_iresp_quiet", 64'(bus.iresp), 64'd0);
      tick();
      bus.mresp = '0;
      bus.dreq  = '0;
      check("sim_gap_idle", 64'(state), 64'(IDLE));
      check("sim_starve1", 64'(starve_cnt), 64'd1);
      tick();
      check("sim_then_i", 64'(state), 64'(GRANT_I));
      answer(64'h0);
      tick();
      clear_inputs();
      check("sim_starve0", 64'(starve_cnt), 64'd0);

      // store, with valid dropped early
      bus.dreq = '{valid: 1'b1, addr: 64'h0000_3008, size: 3'b011, strobe: 8'h0F, data: 64'h1234};
      tick();
      bus.mresp = '{addr_ok: 1'b1, data_ok: 1'b0, data: 64'hFFFF_FFFF_FFFF_FFFF};
      settle();
      check("st_write", 64'(bus.mreq.is_write), 64'd1);
      check("st_strobe", 64'(bus.mreq.strobe), 64'h0F);
      check("st_data", bus.mreq.data, 64'h1234);
      check("st_addr_ok", 64'(bus.dresp.addr_ok), 64'd1);
      check("st_iresp_quiet", 64'(bus.iresp), 64'd0);
      tick();
      bus.dreq.valid = 1'b0;
      bus.mresp = '0;
      tick();
      check("drop_hold", 64'(state), 64'(GRANT_D));
      check("drop_mvalid", 64'(bus.mreq.valid), 64'd1);
      answer(64'h5555_6666_7777_8888);
      settle();
      check("drop_fwd", bus.dresp.data, 64'h5555_6666_7777_8888);
      tick();
      clear_inputs();
      check("st_no_starve", 64'(starve_cnt), 64'd0);

      // starvation: four data grants then the instruction grant
      for (int i = 0; i < 4; i++) exp_q.push_back(64'(GRANT_D));
      exp_q.push_back(64'(GRANT_I));
      bus.ireq = '{valid: 1'b1, addr: 64'h8000_0020};
      bus.dreq = '{valid: 1'b1, addr: 64'h0000_4000, size: 3'b011, strobe: 8'h00, data: 64'h0};
      while (exp_q.size() > 0) begin
         logic [63:0] e;
         tick();
         e = exp_q.pop_front();
         check("starve_seq", 64'(state), e);
         answer(64'h0);
         tick();
         bus.mresp = '0;
      end
      check("starve_clear", 64'(starve_cnt), 64'd0);
      clear_inputs();
      tick();

      // asynchronous reset in the middle of a data grant
      bus.dreq = '{valid: 1'b1, addr: 64'h0000_5000, size: 3'b011, strobe: 8'h00, data: 64'h0};
      tick();
      check("mr_grant", 64'(state), 64'(GRANT_D));
      #1;
      reset = 1'b1;
      #1;
      check("mr_async_mvalid", 64'(bus.mreq.valid), 64'd0);
      check("mr_async_state", 64'(state), 64'(IDLE));
      bus.dreq  = '0;
      tick();
      reset = 1'b0;
      answer(64'hBAD0_BAD0_BAD0_BAD0);
      settle();
      check("mr_late_ok", 64'(bus.dresp.data_ok), 64'd0);
      tick();
      check("mr_stay_idle", 64'(state), 64'(IDLE));
      bus.mresp = '0;
      bus.dreq = '{valid: 1'b1, addr: 64'h0000_6000, size: 3'b011, strobe: 8'h00, data: 64'h0};
      settle();
      check("mr_first_idle", 64'(state), 64'(IDLE));
      tick();
      check("mr_first_grant", 64'(state), 64'(GRANT_D));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: maximum consecutive data grants while an instruction request waits.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: reset is asynchronous and active-high.
REQ-004 SHALL have port ireq, input, ibus_req_t: instruction request {valid, addr[63:0]}.
REQ-005 SHALL have port iresp, output, ibus_resp_t: instruction response {addr_ok, data_ok, data[31:0]}.
REQ-006 SHALL have port dreq, input, dbus_req_t: data request {valid, addr[63:0], size[2:0], strobe[7:0], data[63:0]}.
REQ-007 SHALL have port dresp, output, dbus_resp_t: data response {addr_ok, data_ok, data[63:0]}.
REQ-008 SHALL have port mreq, output, mbus_req_t: shared memory request {valid, is_write, addr[63:0], size[2:0], strobe[7:0], data[63:0]}.
REQ-009 SHALL have port mresp, input, mbus_resp_t: shared memory response {addr_ok, data_ok, data[63:0]}.

Function
REQ-010 SHALL use FSM states IDLE, GRANT_I, GRANT_D.
REQ-011 In IDLE, mreq.valid SHALL be 0 and every iresp/dresp field SHALL be 0.
REQ-012 In IDLE, with only dreq.valid set, next state SHALL be GRANT_D.
REQ-013 In IDLE, with only ireq.valid set, next state SHALL be GRANT_I.
REQ-014 In IDLE, with both valid, next state SHALL be GRANT_D, unless starve_cnt==STARVE_MAX, then GRANT_I.
REQ-015 Arbitration latency SHALL be exactly one cycle: the request is sampled in IDLE and mreq.valid is first asserted the following cycle.
REQ-016 In GRANT_D, mreq SHALL equal the dreq fields with is_write=(strobe!=0); mresp.addr_ok/data_ok/data SHALL pass combinationally to dresp.
REQ-017 In GRANT_I, mreq SHALL carry ireq.addr, size=3'b010, strobe=0, is_write=0.
REQ-018 In GRANT_I, iresp.data SHALL be mresp.data[63:32] if addr[2]=1, else mresp.data[31:0].
REQ-019 The non-granted requester SHALL see addr_ok=data_ok=0 throughout the grant.
REQ-020 The grant SHALL hold until mresp.data_ok=1; on that cycle the state SHALL return to IDLE, with no back-to-back grant without an IDLE cycle.
REQ-021 If the granted requester drops valid before data_ok (protocol violation), the arbiter SHALL keep the grant and forward mresp unchanged.
REQ-022 starve_cnt (width clog2(STARVE_MAX+1)) SHALL increment on each IDLE->GRANT_D decision taken while ireq.valid=1.
REQ-023 starve_cnt SHALL clear on any IDLE->GRANT_I decision and SHALL saturate at STARVE_MAX.
REQ-024 The arbiter SHALL NOT modify address, data or strobe values; size, is_write and the 32-bit lane select are the only derived fields.

Reset
REQ-025 On reset assertion, the state SHALL go to IDLE and starve_cnt to 0 immediately, regardless of clk.
REQ-026 During reset, mreq.valid and every iresp/dresp field SHALL be 0.
REQ-027 Reset mid-grant SHALL abandon the outstanding transaction; a later mresp.data_ok in IDLE SHALL be ignored.
REQ-028 The first grant after reset release SHALL require one IDLE sampling edge.

Structure
REQ-029 ibus/dbus/mbus req/resp structs and the state enum SHALL live in the shared common package.
REQ-030 The block SHALL be a single module with no sub-modules; the FSM and starvation counter are internal.

Verification
REQ-031 Single instruction fetch: ireq addr=0x8000_0004, mresp data_ok after 3 cycles with data=0xAABBCCDD_11223344 -> iresp.data=0xAABBCCDD, one IDLE cycle, then GRANT_I, then IDLE.
REQ-032 Simultaneous requests: ireq and dreq both valid at cycle 0 -> GRANT_D first, GRANT_I granted only after the data transaction's data_ok.
REQ-033 Starvation: ireq held valid, dreq re-asserted continuously, STARVE_MAX=4 -> exactly 4 data grants, then 1 instruction grant, then starve_cnt=0.
REQ-034 Store: dreq strobe=0x0F, data=0x1234 -> mreq.is_write=1, strobe=0x0F, data=0x1234; iresp stays 0.
REQ-035 Reset mid-grant: reset asserted in GRANT_D between clock edges -> mreq.valid=0 with no clock edge; a late data_ok is not forwarded.
